// File: rtl/nibble_microprocessor_pkg.sv
// Shared definitions for the switch-programmed nibble processor:
// opcodes, entry FSM states and 7-segment glyphs ({g,f,e,d,c,b,a}, active-high).
package nibble_microprocessor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP,
    ST_RS,
    ST_RT,
    ST_RD,
    ST_READY,
    ST_EXEC
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_READ  = 4'h2;
  localparam logic [3:0] OP_COPY  = 4'h3;
  localparam logic [3:0] OP_NOT   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NAND  = 4'h8;
  localparam logic [3:0] OP_NOR   = 4'h9;
  localparam logic [3:0] OP_ADD   = 4'hA;
  localparam logic [3:0] OP_SUB   = 4'hB;
  localparam logic [3:0] OP_ADDI  = 4'hC;
  localparam logic [3:0] OP_SUBI  = 4'hD;
  localparam logic [3:0] OP_SHL   = 4'hE;
  localparam logic [3:0] OP_SHR   = 4'hF;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/nibble_microprocessor_if.sv
// Board-side signal bundle: switch/button/blink inputs and LED/7-segment outputs.
interface nibble_microprocessor_if;
  logic       clk_10;
  logic [3:0] sw;
  logic [3:0] btn;
  logic [3:0] led;
  logic [1:0] seg_en;
  logic [6:0] seg_ab;
  logic [6:0] seg_cd;

  modport master (output clk_10, sw, btn, input led, seg_en, seg_ab, seg_cd);
  modport slave  (input clk_10, sw, btn, output led, seg_en, seg_ab, seg_cd);
endinterface

// File: rtl/nibble_microprocessor_seg7_decode.sv
// 4-bit value to hexadecimal 7-segment glyph.
module seg7_decode
  import nibble_microprocessor_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);
  assign seg = hex_glyph(value);
endmodule

// File: rtl/nibble_microprocessor.sv
// Top level: synchronised switch/button entry of {op,rs,rt,rd}, 16x4 register file,
// ALU with signed-overflow blink, and multiplexed 7-segment display pairs.
module nibble_microprocessor
  import nibble_microprocessor_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 16,
  parameter int unsigned SYNC_STAGES  = 2
)(
  input  logic                    clk,
  input  logic                    rst_n,
  nibble_microprocessor_if.slave  bus
);

  // {clk_10, sw[3:0], btn[1:0]}; btn[3:2] carry no function
  logic [6:0] sync_q [SYNC_STAGES];
  logic [6:0] sync_out;
  logic       unused_btn;
  logic       clk10_s;
  logic [3:0] sw_s;
  logic [1:0] btn_s, btn_prev_q, btn_evt;
  logic       step, cancel;

  assign unused_btn = ^bus.btn[3:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      btn_prev_q <= '0;
    end else begin
      sync_q[0] <= {bus.clk_10, bus.sw, bus.btn[1:0]};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      btn_prev_q <= btn_s;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign clk10_s  = sync_out[6];
  assign sw_s     = sync_out[5:2];
  assign btn_s    = sync_out[1:0];
  assign btn_evt  = btn_s & ~btn_prev_q;
  assign step     = btn_evt[0];
  assign cancel   = btn_evt[1];

  state_t state_q, state_d;
  logic   lat_op, lat_rs, lat_rt, lat_rd, do_exec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (step) state_d = ST_OP;
      ST_EXEC:  state_d = ST_IDLE;
      ST_OP:    if (cancel) state_d = ST_IDLE; else if (step) state_d = ST_RS;
      ST_RS:    if (cancel) state_d = ST_IDLE; else if (step) state_d = ST_RT;
      ST_RT:    if (cancel) state_d = ST_IDLE; else if (step) state_d = ST_RD;
      ST_RD:    if (cancel) state_d = ST_IDLE; else if (step) state_d = ST_READY;
      ST_READY: if (cancel) state_d = ST_IDLE; else if (step) state_d = ST_EXEC;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lat_op  = (state_q == ST_OP) && step && !cancel;
    lat_rs  = (state_q == ST_RS) && step && !cancel;
    lat_rt  = (state_q == ST_RT) && step && !cancel;
    lat_rd  = (state_q == ST_RD) && step && !cancel;
    do_exec = (state_q == ST_EXEC);
  end

  logic [3:0] op_q, rs_q, rt_q, rd_q, result_q;
  logic       ovf_q;
  logic [3:0] regs_q [16];
  logic [3:0] a, b, b_sel, add_res, sub_res, alu_res;
  logic       alu_ovf, alu_wr;

  assign a       = regs_q[rs_q];
  assign b       = regs_q[rt_q];
  assign b_sel   = (op_q == OP_ADD || op_q == OP_SUB) ? b : rt_q;
  assign add_res = a + b_sel;
  assign sub_res = a - b_sel;

  always_comb begin
    alu_res = result_q;
    alu_ovf = 1'b0;
    alu_wr  = 1'b1;
    unique case (op_q)
      OP_NOP:   begin alu_wr = 1'b0; alu_ovf = ovf_q; end
      OP_WRITE: alu_res = rt_q;
      OP_READ:  begin alu_res = a; alu_wr = 1'b0; end
      OP_COPY:  alu_res = a;
      OP_NOT:   alu_res = ~a;
      OP_AND:   alu_res = a & b;
      OP_OR:    alu_res = a | b;
      OP_XOR:   alu_res = a ^ b;
      OP_NAND:  alu_res = ~(a & b);
      OP_NOR:   alu_res = ~(a | b);
      OP_ADD, OP_ADDI: begin
        alu_res = add_res;
        alu_ovf = (a[3] == b_sel[3]) && (add_res[3] != a[3]);
      end
      OP_SUB, OP_SUBI: begin
        alu_res = sub_res;
        alu_ovf = (a[3] != b_sel[3]) && (sub_res[3] != a[3]);
      end
      OP_SHL:   alu_res = a << rt_q;
      default:  alu_res = a >> rt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      if (lat_op) op_q <= sw_s;
      if (lat_rs) rs_q <= sw_s;
      if (lat_rt) rt_q <= sw_s;
      if (lat_rd) rd_q <= sw_s;
      if (do_exec && op_q != OP_NOP) begin
        result_q <= alu_res;
        ovf_q    <= alu_ovf;
        if (alu_wr) regs_q[rd_q] <= alu_res;
      end
    end
  end

  logic [REFRESH_BITS-1:0] refresh_q;
  logic [1:0]              seg_en_q;
  logic [3:0]              mag;
  logic [6:0]              op_glyph, rd_glyph, mag_glyph, sign_glyph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      seg_en_q  <= 2'b01;
    end else begin
      refresh_q <= refresh_q + 1'b1;
      if (&refresh_q) seg_en_q <= {seg_en_q[0], seg_en_q[1]};
    end
  end

  // -8 negates to itself and still reads as 8 on the hex glyph
  assign mag        = result_q[3] ? (~result_q + 4'd1) : result_q;
  assign sign_glyph = result_q[3] ? SEG_MINUS : SEG_BLANK;

  seg7_decode u_op_dec  (.value(op_q), .seg(op_glyph));
  seg7_decode u_rd_dec  (.value(rd_q), .seg(rd_glyph));
  seg7_decode u_mag_dec (.value(mag),  .seg(mag_glyph));

  assign bus.led    = ovf_q ? (result_q & {4{clk10_s}}) : result_q;
  assign bus.seg_en = seg_en_q;
  assign bus.seg_ab = seg_en_q[0] ? rd_glyph  : op_glyph;
  assign bus.seg_cd = seg_en_q[0] ? mag_glyph : sign_glyph;

endmodule

// File: tb/tb_nibble_microprocessor.sv
// Scoreboard bench: stimulus keys instructions and queues expected LED/display state,
// a monitor pops and compares whenever a commit has settled.
module tb_nibble_microprocessor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_microprocessor_if bus();

  nibble_microprocessor #(.REFRESH_BITS(2), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [3:0] led;
    bit         blink;
    bit         disp;
    logic [6:0] abl, abr, cdl, cdr;
  } exp_t;

  exp_t       sb[$];
  event       obs;
  int         checks = 0;
  int         errors = 0;
  logic [6:0] gl [16];

  initial begin
    gl[0]=7'h3F; gl[1]=7'h06; gl[2]=7'h5B; gl[3]=7'h4F;
    gl[4]=7'h66; gl[5]=7'h6D; gl[6]=7'h7D; gl[7]=7'h07;
    gl[8]=7'h7F; gl[9]=7'h6F; gl[10]=7'h77; gl[11]=7'h7C;
    gl[12]=7'h39; gl[13]=7'h5E; gl[14]=7'h79; gl[15]=7'h71;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    bus.clk_10 = 1'b0;
    forever #50 bus.clk_10 = ~bus.clk_10;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_seg(input string name, input logic [1:0] want);
    int n = 0;
    while (bus.seg_en !== want && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk({name, " seg_en"}, {6'b0, bus.seg_en}, {6'b0, want});
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(obs);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: observation with empty queue");
      end else begin
        e = sb.pop_front();
        if (e.blink)
          chk({e.name, " led"}, {7'b0, (bus.led == e.led || bus.led == 4'b0)}, 8'h01);
        else
          chk({e.name, " led"}, {4'b0, bus.led}, {4'b0, e.led});
        if (e.disp) begin
          wait_seg(e.name, 2'b01);
          chk({e.name, " ab_r"}, {1'b0, bus.seg_ab}, {1'b0, e.abr});
          chk({e.name, " cd_r"}, {1'b0, bus.seg_cd}, {1'b0, e.cdr});
          wait_seg(e.name, 2'b10);
          chk({e.name, " ab_l"}, {1'b0, bus.seg_ab}, {1'b0, e.abl});
          chk({e.name, " cd_l"}, {1'b0, bus.seg_cd}, {1'b0, e.cdl});
        end
      end
    end
  end

  task automatic pulse(input int b);
    @(posedge clk); #1 bus.btn[b] = 1'b1;
    @(posedge clk); #1 bus.btn[b] = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic key(input logic [3:0] nib);
    @(posedge clk); #1 bus.sw = nib;
    pulse(0);
  endtask

  task automatic expect_state(input string name, input logic [3:0] op, input logic [3:0] rd,
                              input logic [3:0] res, input bit blink, input bit disp);
    exp_t e;
    logic [3:0] m;
    m = res[3] ? (~res + 4'd1) : res;
    e.name = name; e.led = res; e.blink = blink; e.disp = disp;
    e.abl = gl[op]; e.abr = gl[rd];
    e.cdl = res[3] ? 7'h40 : 7'h00;
    e.cdr = gl[m];
    sb.push_back(e);
    -> obs;
    repeat (24) @(posedge clk);
  endtask

  task automatic run(input string name, input logic [3:0] op, rs, rt, rd,
                     input logic [3:0] res, input bit blink);
    pulse(0);
    key(op); key(rs); key(rt); key(rd);
    @(posedge clk); #1 bus.btn[0] = 1'b1;
    @(posedge clk); #1 bus.btn[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (!blink) chk({name, " latency"}, {4'b0, bus.led}, {4'b0, res});
    expect_state(name, op, rd, res, blink, 1'b1);
  endtask

  task automatic blink_check(input string name, input logic [3:0] res, input bit blink);
    int hi = 0, lo = 0, bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.led == res) hi++;
      else if (bus.led == 4'b0) lo++;
      else bad++;
    end
    if (blink) chk({name, " blink"}, {5'b0, hi > 0, lo > 0, bad == 0}, 8'h07);
    else       chk({name, " steady"}, 8'(lo + bad), 8'h00);
  endtask

  initial begin
    bus.sw = '0;
    bus.btn = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset led", {4'b0, bus.led}, 8'h00);
    chk("reset seg_en", {6'b0, bus.seg_en}, 8'h01);
    @(posedge clk); #1 rst_n = 1'b1;
    expect_state("reset", 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);

    run("addi",  4'hC, 4'h1, 4'h5, 4'h1, 4'b0101, 1'b0);
    run("subi",  4'hD, 4'h2, 4'h6, 4'h2, 4'b1010, 1'b0);
    run("add",   4'hA, 4'h1, 4'h2, 4'h3, 4'b1111, 1'b0);
    run("write", 4'h1, 4'h0, 4'h7, 4'h4, 4'b0111, 1'b0);
    run("sub_ovf", 4'hB, 4'h4, 4'h2, 4'h5, 4'b1101, 1'b1);
    blink_check("sub_ovf", 4'b1101, 1'b1);
    run("not",   4'h4, 4'h3, 4'h0, 4'h5, 4'b0000, 1'b0);
    run("copy",  4'h3, 4'h4, 4'h0, 4'h7, 4'b0111, 1'b0);
    run("and",   4'h5, 4'h4, 4'h2, 4'h8, 4'b0010, 1'b0);
    run("or",    4'h6, 4'h4, 4'h2, 4'h9, 4'b1111, 1'b0);
    run("xor",   4'h7, 4'h4, 4'h2, 4'hA, 4'b1101, 1'b0);
    run("nand",  4'h8, 4'h4, 4'h2, 4'hB, 4'b1101, 1'b0);
    blink_check("nand", 4'b1101, 1'b0);
    run("nor",   4'h9, 4'h5, 4'h5, 4'h2, 4'b1111, 1'b0);
    run("shl",   4'hE, 4'h2, 4'h3, 4'h0, 4'b1000, 1'b0);
    run("shr",   4'hF, 4'h2, 4'h1, 4'h5, 4'b0111, 1'b0);
    run("shr4",  4'hF, 4'h2, 4'h4, 4'h6, 4'b0000, 1'b0);
    run("read2", 4'h2, 4'h2, 4'h0, 4'h0, 4'b1111, 1'b0);
    run("read0", 4'h2, 4'h0, 4'h0, 4'h0, 4'b1000, 1'b0);

    run("add_self_ovf", 4'hA, 4'h1, 4'h1, 4'h1, 4'b1010, 1'b1);
    run("nop", 4'h0, 4'h3, 4'h3, 4'h3, 4'b1010, 1'b1);
    blink_check("nop", 4'b1010, 1'b1);
    run("read3", 4'h2, 4'h3, 4'h0, 4'h0, 4'b1111, 1'b0);
    run("read1", 4'h2, 4'h1, 4'h0, 4'h0, 4'b1010, 1'b0);
    blink_check("read1", 4'b1010, 1'b0);

    pulse(0); key(4'hC); key(4'h1);
    pulse(1);
    expect_state("cancel", 4'h0, 4'h0, 4'b1010, 1'b0, 1'b0);
    run("addi_after_cancel", 4'hC, 4'h1, 4'h2, 4'h6, 4'b1100, 1'b0);

    pulse(0); key(4'hB); key(4'h6);
    @(posedge clk); #1 bus.btn[1:0] = 2'b11;
    @(posedge clk); #1 bus.btn[1:0] = 2'b00;
    repeat (6) @(posedge clk);
    expect_state("cancel_prio", 4'h0, 4'h0, 4'b1100, 1'b0, 1'b0);
    run("read6", 4'h2, 4'h6, 4'h0, 4'h0, 4'b1100, 1'b0);

    pulse(0); key(4'h5); key(4'h3);
    @(posedge clk); #3 rst_n = 1'b0;
    #2;
    chk("midreset led", {4'b0, bus.led}, 8'h00);
    chk("midreset seg_en", {6'b0, bus.seg_en}, 8'h01);
    chk("midreset seg_ab", {1'b0, bus.seg_ab}, 8'h3F);
    chk("midreset seg_cd", {1'b0, bus.seg_cd}, 8'h3F);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    run("addi_after_reset", 4'hC, 4'h1, 4'h1, 4'h1, 4'b0001, 1'b0);

    repeat (30) @(posedge clk);
    chk("queue drained", 8'(sb.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
